// File: rtl/multiword_add_seq.sv
// Wide adder built from one N-bit ripple adder, one slice per cycle; result valid WORDS edges after accept.
// Backpressure: accepts only in IDLE; holds result in DONE until out_ready; one op per WORDS+2 cycles.

module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[N];
endmodule

module multiword_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cout_q, cout_d;

  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cout;

  assign add_a = a_q[int'(idx_q)*N +: N];
  assign add_b = b_q[int'(idx_q)*N +: N];

  ripple_carry_adder #(.N(N)) u_rca (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Carry crosses slice boundaries only through carry_q.
        sum_d[int'(idx_q)*N +: N] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: a 4x4 instance for the main scenarios and a
// single-slice instance for the WORDS=1 corner.

module tb_multiword_add_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, in_cin;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_cout, busy;
  logic [15:0] out_sum;

  logic        in_valid1, out_ready1, in_cin1;
  logic [3:0]  in_a1, in_b1;
  logic        in_ready1, out_valid1, out_cout1, busy1;
  logic [3:0]  out_sum1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiword_add_seq #(.N(4), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  multiword_add_seq #(.N(4), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, measure latency to out_valid, check and consume the result.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] esum, input logic ecout);
    int n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(out_sum), 32'(esum));
    chk({tag, "_cout"}, 32'(out_cout), 32'(ecout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  logic [15:0] sa [3] = '{16'h0001, 16'h7FFF, 16'hF00F};
  logic [15:0] sb [3] = '{16'h0002, 16'h0001, 16'h1FF1};
  logic        sc [3] = '{1'b1, 1'b0, 1'b0};
  logic [15:0] ss [3] = '{16'h0004, 16'h8000, 16'h1000};
  logic        so [3] = '{1'b0, 1'b0, 1'b1};
  int          acc_cyc [3];

  initial begin
    int n, idx_in, idx_out;
    logic hs;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_cin = 1'b0; in_a = '0; in_b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_cin1 = 1'b0; in_a1 = '0; in_b1 = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_op("basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Result held in DONE while new input data is offered.
    in_a = 16'hA5A5; in_b = 16'h5A5A; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("hold_latency", 32'(n), 32'd4);
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'hFFFF);
      chk("hold_cout", 32'(out_cout), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    chk("hold_release_busy", 32'(busy), 32'd0);
    chk("hold_sum_kept", 32'(out_sum), 32'hFFFF);
    tick();
    chk("hold_no_capture", 32'(busy), 32'd0);

    // Reset two cycles into RUN aborts the operation.
    in_a = 16'h00FF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(out_sum), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    do_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // Back-to-back stream with both handshakes held asserted.
    idx_in = 0; idx_out = 0;
    in_a = sa[0]; in_b = sb[0]; in_cin = sc[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && idx_out < 3; c++) begin
      hs = in_valid && in_ready;
      if (out_valid) begin
        chk("stream_sum", 32'(out_sum), 32'(ss[idx_out]));
        chk("stream_cout", 32'(out_cout), 32'(so[idx_out]));
        idx_out++;
      end
      tick();
      if (hs) begin
        acc_cyc[idx_in] = cyc;
        idx_in++;
        if (idx_in < 3) begin
          in_a = sa[idx_in]; in_b = sb[idx_in]; in_cin = sc[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_results", 32'(idx_out), 32'd3);
    chk("stream_accepts", 32'(idx_in), 32'd3);
    chk("stream_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("stream_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

    // Single-slice instance.
    chk("w1_in_ready", 32'(in_ready1), 32'd1);
    in_a1 = 4'hF; in_b1 = 4'h1; in_cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin tick(); n++; end
    chk("w1_latency", 32'(n), 32'd1);
    chk("w1_sum", 32'(out_sum1), 32'h0);
    chk("w1_cout", 32'(out_cout1), 32'd1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("w1_valid_clr", 32'(out_valid1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
